// File: rtl/trng_lfsr_pool.sv
// Entropy-conditioning LFSR: synchronised ring-oscillator bits are XOR-folded into a Fibonacci
// LFSR, and after warm-up the block emits words over valid/ready with overrun/stuck health flags.
module trng_lfsr_pool #(
    parameter int unsigned      WIDTH         = 16,
    parameter logic [WIDTH-1:0] POLYNOM       = 16'hB400,
    parameter int unsigned      CHANNELS      = 4,
    parameter int unsigned      OUT_WIDTH     = 8,
    parameter int unsigned      WARMUP_SHIFTS = 64,
    parameter int unsigned      STUCK_LIMIT   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 seed_we,
    input  logic [WIDTH-1:0]     seed,
    input  logic [CHANNELS-1:0]  ro_in,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 warmup_done,
    output logic                 overrun,
    output logic                 stuck_err
);

    localparam int unsigned WarmW  = $clog2(WARMUP_SHIFTS + 1);
    localparam int unsigned BitW   = $clog2(OUT_WIDTH + 1);
    localparam int unsigned StuckW = $clog2(STUCK_LIMIT + 1);

    localparam logic [WarmW-1:0]  WarmLast = WarmW'(WARMUP_SHIFTS - 1);
    localparam logic [BitW-1:0]   BitLast  = BitW'(OUT_WIDTH - 1);
    localparam logic [StuckW-1:0] StuckMax = StuckW'(STUCK_LIMIT);

    typedef enum logic [1:0] {StIdle, StWarmup, StRun, StFault} state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      lfsr_q, lfsr_d;
    logic [CHANNELS-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
    logic                  prev_ent_q, prev_ent_d;
    logic [WarmW-1:0]      warm_cnt_q, warm_cnt_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [StuckW-1:0]     stuck_cnt_q, stuck_cnt_d;
    logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  overrun_q, overrun_d;
    logic                  stuck_err_q, stuck_err_d;
    logic                  warmup_done_q, warmup_done_d;

    logic                  ent;
    logic                  fb;
    logic [WIDTH-1:0]      lfsr_shift;
    logic [StuckW-1:0]     stuck_nxt;

    assign ent        = ^sync2_q;
    assign fb         = (^(lfsr_q & POLYNOM)) ^ ent;
    assign lfsr_shift = {fb, lfsr_q[WIDTH-1:1]};

    always_comb begin
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        sync1_d       = ro_in;
        sync2_d       = sync1_q;
        prev_ent_d    = prev_ent_q;
        warm_cnt_d    = warm_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        stuck_cnt_d   = stuck_cnt_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        overrun_d     = overrun_q;
        stuck_err_d   = stuck_err_q;
        stuck_nxt     = '0;

        if (ent == prev_ent_q) begin
            stuck_nxt = (stuck_cnt_q == StuckMax) ? stuck_cnt_q : stuck_cnt_q + 1'b1;
        end

        if (seed_we) begin
            state_d     = StWarmup;
            lfsr_d      = seed;
            prev_ent_d  = 1'b0;
            warm_cnt_d  = '0;
            bit_cnt_d   = '0;
            stuck_cnt_d = '0;
            out_valid_d = 1'b0;
            overrun_d   = 1'b0;
            stuck_err_d = 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (en) begin
                        state_d = StWarmup;
                    end
                end
                StWarmup, StRun: begin
                    if (en) begin
                        lfsr_d      = lfsr_shift;
                        prev_ent_d  = ent;
                        stuck_cnt_d = stuck_nxt;
                        if (stuck_nxt == StuckMax) begin
                            state_d     = StFault;
                            stuck_err_d = 1'b1;
                            out_valid_d = 1'b0;
                        end else if (state_q == StWarmup) begin
                            warm_cnt_d = warm_cnt_q + 1'b1;
                            if (warm_cnt_q == WarmLast) begin
                                state_d   = StRun;
                                bit_cnt_d = '0;
                            end
                        end else if (bit_cnt_q == BitLast) begin
                            bit_cnt_d = '0;
                            // An unconsumed word that is not being taken this edge wins.
                            if (out_valid_q && !out_ready) begin
                                overrun_d = 1'b1;
                            end else begin
                                out_data_d  = lfsr_shift[OUT_WIDTH-1:0];
                                out_valid_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                StFault: begin
                    out_valid_d = 1'b0;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        warmup_done_d = (state_d == StRun);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            lfsr_q        <= '0;
            sync1_q       <= '0;
            sync2_q       <= '0;
            prev_ent_q    <= 1'b0;
            warm_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            stuck_cnt_q   <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            overrun_q     <= 1'b0;
            stuck_err_q   <= 1'b0;
            warmup_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_ent_q    <= prev_ent_d;
            warm_cnt_q    <= warm_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            stuck_cnt_q   <= stuck_cnt_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            overrun_q     <= overrun_d;
            stuck_err_q   <= stuck_err_d;
            warmup_done_q <= warmup_done_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign overrun     = overrun_q;
    assign stuck_err   = stuck_err_q;
    assign warmup_done = warmup_done_q;

endmodule

// File: tb/tb_trng_lfsr_pool.sv
// Bench for trng_lfsr_pool: scenario tasks compared against a shift-count based reference model.
module tb_trng_lfsr_pool;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       seed_we;
    logic [9:0] seed;
    logic [1:0] ro_in;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       warmup_done;
    logic       overrun;
    logic       stuck_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    trng_lfsr_pool #(
        .WIDTH        (10),
        .POLYNOM      (10'h204),
        .CHANNELS     (2),
        .OUT_WIDTH    (8),
        .WARMUP_SHIFTS(16),
        .STUCK_LIMIT  (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .seed_we    (seed_we),
        .seed       (seed),
        .ro_in      (ro_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .warmup_done(warmup_done),
        .overrun    (overrun),
        .stuck_err  (stuck_err)
    );

    // Model: 0 idle, 1 active (warm-up or run, told apart by shift count), 2 fault.
    int         m_state;
    int         m_lfsr;
    int         m_n;
    int         m_run;
    int         m_prev;
    int         m_od;
    logic [1:0] m_ro1, m_ro2;
    logic       m_ov, m_ovr, m_serr;

    function automatic logic exp_wd();
        return (m_state == 1) && (m_n >= 16);
    endfunction

    task automatic model_reset();
        m_state = 0; m_lfsr = 0; m_n = 0; m_run = 0; m_prev = 0; m_od = 0;
        m_ro1 = '0; m_ro2 = '0; m_ov = 0; m_ovr = 0; m_serr = 0;
    endtask

    task automatic model_edge();
        int   ent;
        int   fb;
        logic old_ov;
        ent   = $countones(m_ro2) % 2;
        m_ro2 = m_ro1;
        m_ro1 = ro_in;
        if (seed_we) begin
            m_lfsr = int'(seed); m_n = 0; m_run = 0; m_prev = 0;
            m_ov = 0; m_ovr = 0; m_serr = 0; m_state = 1;
        end else begin
            old_ov = m_ov;
            if (m_ov && out_ready) m_ov = 0;
            if (m_state == 0) begin
                if (en) m_state = 1;
            end else if (m_state == 2) begin
                m_ov = 0;
            end else if (en) begin
                fb     = ($countones(m_lfsr & 'h204) % 2) ^ ent;
                m_lfsr = (m_lfsr >> 1) + fb * 512;
                m_run  = (ent == m_prev) ? m_run + 1 : 0;
                m_prev = ent;
                m_n++;
                if (m_run == 32) begin
                    m_state = 2; m_serr = 1; m_ov = 0;
                end else if (m_n > 16 && (m_n - 16) % 8 == 0) begin
                    if (old_ov && !out_ready) m_ovr = 1;
                    else begin
                        m_od = m_lfsr % 256;
                        m_ov = 1;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic load_seed(input logic [9:0] s);
        seed_we = 1'b1; seed = s; en = 1'b1;
        tick();
        seed_we = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset.valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset.data got %h exp 00", out_data); end
        checks++; if (warmup_done !== 1'b0) begin errors++; $display("FAIL reset.wd got %b exp 0", warmup_done); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset.ovr got %b exp 0", overrun); end
        checks++; if (stuck_err !== 1'b0) begin errors++; $display("FAIL reset.stuck got %b exp 0", stuck_err); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dut.lfsr_q !== 10'h000) begin
                errors++; $display("FAIL idle.lfsr got %h exp 000", dut.lfsr_q);
            end
        end
    endtask

    task automatic test_seed_shift();
        ro_in = 2'b00; out_ready = 1'b1;
        load_seed(10'h004);
        checks++; if (dut.lfsr_q !== 10'h004) begin errors++; $display("FAIL seed.nos got %h exp 004", dut.lfsr_q); end
        tick();
        checks++; if (dut.lfsr_q !== 10'h202) begin errors++; $display("FAIL seed.sh1 got %h exp 202", dut.lfsr_q); end
        tick();
        checks++; if (dut.lfsr_q !== 10'h301) begin errors++; $display("FAIL seed.sh2 got %h exp 301", dut.lfsr_q); end
        checks++; if (dut.lfsr_q !== 10'(m_lfsr)) begin errors++; $display("FAIL seed.model got %h exp %h", dut.lfsr_q, 10'(m_lfsr)); end
    endtask

    task automatic test_stuck();
        logic [9:0] frozen;
        ro_in = 2'b00; out_ready = 1'b1;
        load_seed(10'h004);
        for (int i = 1; i <= 40; i++) begin
            tick();
            checks++;
            if (stuck_err !== m_serr || warmup_done !== exp_wd() || out_valid !== m_ov) begin
                errors++;
                $display("FAIL stuck.flags shift %0d got se=%b wd=%b v=%b exp se=%b wd=%b v=%b",
                         i, stuck_err, warmup_done, out_valid, m_serr, exp_wd(), m_ov);
            end
            if (i == 15 || i == 16) begin
                checks++;
                if (warmup_done !== (i == 16)) begin
                    errors++; $display("FAIL stuck.wd shift %0d got %b exp %b", i, warmup_done, i == 16);
                end
            end
            if (i == 31 || i == 32) begin
                checks++;
                if (stuck_err !== (i == 32)) begin
                    errors++; $display("FAIL stuck.err shift %0d got %b exp %b", i, stuck_err, i == 32);
                end
            end
            if (i == 32) frozen = 10'(m_lfsr);
        end
        checks++;
        if (dut.lfsr_q !== frozen) begin
            errors++; $display("FAIL stuck.frozen got %h exp %h", dut.lfsr_q, frozen);
        end
    endtask

    task automatic test_output_timing();
        ro_in = 2'b00; out_ready = 1'b1;
        load_seed(10'h2A5);
        for (int i = 1; i <= 64; i++) begin
            ro_in[0] = ~ro_in[0];
            tick();
            checks++;
            if (out_valid !== (i >= 24 && (i - 24) % 8 == 0)) begin
                errors++; $display("FAIL timing.valid shift %0d got %b exp %b",
                                   i, out_valid, (i >= 24 && (i - 24) % 8 == 0));
            end
            checks++;
            if (out_data !== 8'(m_od) || overrun !== 1'b0) begin
                errors++; $display("FAIL timing.data shift %0d got %h/%b exp %h/0",
                                   i, out_data, overrun, 8'(m_od));
            end
        end
    endtask

    task automatic test_backpressure();
        int first;
        out_ready = 1'b0;
        load_seed(10'h13C);
        first = -1;
        for (int i = 1; i <= 40; i++) begin
            ro_in = 2'($urandom);
            tick();
            if (i == 24) first = m_od;
        end
        checks++;
        if (overrun !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp.flags got ovr=%b v=%b exp 1/1", overrun, out_valid);
        end
        checks++;
        if (out_data !== 8'(first)) begin
            errors++; $display("FAIL bp.hold got %h exp %h", out_data, 8'(first));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || overrun !== 1'b1) begin
            errors++; $display("FAIL bp.drain got v=%b ovr=%b exp 0/1", out_valid, overrun);
        end
    endtask

    task automatic test_simultaneous();
        load_seed(10'h3C3);
        checks++;
        if (dut.lfsr_q !== 10'h3C3 || out_valid !== 1'b0 || overrun !== 1'b0 || warmup_done !== 1'b0) begin
            errors++; $display("FAIL simul.seed got lfsr=%h v=%b ovr=%b wd=%b exp 3c3/0/0/0",
                               dut.lfsr_q, out_valid, overrun, warmup_done);
        end
        for (int i = 1; i <= 32; i++) begin
            ro_in     = 2'($urandom);
            out_ready = (i == 32);
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || overrun !== 1'b0) begin
            errors++; $display("FAIL simul.xfer got v=%b ovr=%b exp 1/0", out_valid, overrun);
        end
        checks++;
        if (out_data !== 8'(m_od)) begin
            errors++; $display("FAIL simul.data got %h exp %h", out_data, 8'(m_od));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            seed_we   = ($urandom_range(63) == 0);
            seed      = 10'($urandom);
            en        = ($urandom_range(7) != 0);
            out_ready = 1'($urandom);
            ro_in     = 2'($urandom);
            tick();
            checks++;
            if (out_valid !== m_ov || out_data !== 8'(m_od) || overrun !== m_ovr ||
                stuck_err !== m_serr || warmup_done !== exp_wd()) begin
                errors++;
                $display("FAIL random cyc %0d got v=%b d=%h o=%b s=%b w=%b exp v=%b d=%h o=%b s=%b w=%b",
                         i, out_valid, out_data, overrun, stuck_err, warmup_done,
                         m_ov, 8'(m_od), m_ovr, m_serr, exp_wd());
            end
        end
        seed_we = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1; ro_in = 2'b00;
        load_seed(10'h155);
        for (int i = 1; i <= 30; i++) begin
            ro_in[0] = ~ro_in[0];
            tick();
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || warmup_done !== 1'b0 ||
            overrun !== 1'b0 || stuck_err !== 1'b0 || dut.lfsr_q !== 10'h000) begin
            errors++; $display("FAIL rstmid.async got v=%b d=%h w=%b o=%b s=%b l=%h exp all 0",
                               out_valid, out_data, warmup_done, overrun, stuck_err, dut.lfsr_q);
        end
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            ro_in = 2'($urandom);
            tick();
        end
        en = 1'b1;
        tick();
        checks++;
        if (dut.lfsr_q !== 10'h000 || warmup_done !== 1'b0) begin
            errors++; $display("FAIL rstmid.idle got lfsr=%h wd=%b exp 000/0", dut.lfsr_q, warmup_done);
        end
        for (int i = 0; i < 20; i++) begin
            ro_in = 2'($urandom);
            tick();
            checks++;
            if (dut.lfsr_q !== 10'(m_lfsr) || warmup_done !== exp_wd()) begin
                errors++; $display("FAIL rstmid.run cyc %0d got %h/%b exp %h/%b",
                                   i, dut.lfsr_q, warmup_done, 10'(m_lfsr), exp_wd());
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; seed_we = 1'b0; seed = '0; ro_in = '0; out_ready = 1'b0;
        model_reset();
        #12;
        test_reset();
        test_seed_shift();
        test_stuck();
        test_output_timing();
        test_backpressure();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trng_lfsr_pool.md
# trng_lfsr_pool

Multi-channel entropy-conditioning LFSR for the TRNG datapath. It samples CHANNELS free-running ring-oscillator inputs through two-flop synchronisers and XOR-folds them into one entropy bit per shift. That bit is injected into a parametrised Fibonacci LFSR. After a warm-up period, the block emits OUT_WIDTH-bit words over a valid/ready handshake, with overrun and stuck-entropy health flags. It sits between the ring-oscillator bank and the downstream random-word consumer.

## Interface
- WIDTH, 16: LFSR length in bits (≥ 4).
- POLYNOM, 16'hB400: tap mask; bit i set means LFSR bit i feeds back.
- CHANNELS, 4: number of ring-oscillator inputs (≥ 1).
- OUT_WIDTH, 8: output word width (≤ WIDTH).
- WARMUP_SHIFTS, 64: shifts discarded after reset or seed load before the first word (≥ 1).
- STUCK_LIMIT, 32: consecutive identical entropy bits that declare a fault (≥ 2).

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  shift enable; low pauses all shifting and counters.
- seed_we  in  1  load seed into LFSR (one-cycle pulse).
- seed  in  WIDTH  seed value.
- ro_in  in  CHANNELS  asynchronous ring-oscillator outputs.
- out_data  out  OUT_WIDTH  random word.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts the word.
- warmup_done  out  1  high in RUN state.
- overrun  out  1  sticky: a completed word was dropped.
- stuck_err  out  1  sticky: entropy stuck, block in FAULT.

## Operation
- Each ro_in bit passes through a two-flop synchroniser, which resets to 0.
- ent = XOR of all synchronised bits.
- prev_ent register holds the last shifted-in entropy bit; it resets to 0.
- Feedback: fb = (XOR over i of POLYNOM[i] & lfsr[i]) ^ ent.
- A shift sets lfsr <= {fb, lfsr[WIDTH-1:1]}.
- A shift occurs on a clk edge when en=1, seed_we=0, and state is WARMUP or RUN.
- Priority order is rst, then seed_we, then en.
- States:
  - IDLE: reset state. Moves to WARMUP on the first edge with en=1. No shift on that edge.
  - WARMUP: warm_cnt counts shifts. On the shift that brings warm_cnt to WARMUP_SHIFTS, move to RUN and clear bit_cnt.
  - RUN: bit_cnt counts shifts modulo OUT_WIDTH. The shift on which bit_cnt = OUT_WIDTH-1 completes a word, and bit_cnt wraps to 0.
  - FAULT: no shifts. out_valid is forced to 0. Only seed_we or rst leaves this state.
- Word completion:
  - out_data <= low OUT_WIDTH bits of the post-shift LFSR value, and out_valid <= 1, on the same edge.
  - If out_valid=1 and out_ready=0 at that edge, the new word is discarded, out_data is held, and overrun is set.
- Handshake:
  - A transfer happens at an edge with out_valid=1 and out_ready=1. out_valid falls on that edge.
  - If a word completes on the same edge as a transfer, out_valid stays 1 with the new data, and this is not an overrun.
  - out_data is stable while out_valid=1 and no transfer has occurred.
- Stuck detector, evaluated per shift:
  - If ent == prev_ent, stuck_cnt increments; otherwise it clears to 0.
  - prev_ent <= ent.
  - When stuck_cnt reaches STUCK_LIMIT, on that shift's edge: state → FAULT, stuck_err=1, out_valid=0.
- seed_we (any state):
  - lfsr <= seed.
  - warm_cnt, bit_cnt, stuck_cnt, prev_ent, out_valid, overrun, stuck_err all cleared.
  - State → WARMUP.
  - en is ignored that cycle.
- All counters are sized $clog2(limit+1) and saturate/clear as described; they never wrap.

## Timing
- Reset values (asynchronous): lfsr=0, all counters 0, state IDLE, out_data=0, out_valid=0, warmup_done=0, overrun=0, stuck_err=0.
- Assertion of rst mid-operation takes effect immediately, without waiting for clk.
- ro_in to ent latency is 2 clk cycles.
- With en held high, the first out_valid comes exactly WARMUP_SHIFTS+OUT_WIDTH shifts after the load.
- Thereafter, one word is produced every OUT_WIDTH enabled cycles.
- warmup_done rises on the edge of the WARMUP_SHIFTS-th shift.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use WIDTH=10, POLYNOM=10'h204, CHANNELS=2, OUT_WIDTH=8, WARMUP_SHIFTS=16, STUCK_LIMIT=32.
- Seed and shift: seed_we with seed=10'h004, ro_in=0, en=1 → lfsr 10'h202 after shift 1, 10'h301 after shift 2.
- Stuck fault: from the same seed, hold ro_in=0 → stuck_err=1 and state FAULT on the edge of shift 32; warmup_done=1 from shift 16; no shifts occur afterwards.
- Output timing: toggle ro_in[0] every cycle, en=1, out_ready=1 → first out_valid on shift 24, then one word every 8 cycles; out_data equals the low 8 bits of a software model's LFSR.
- Backpressure: out_ready=0 across two word completions → overrun=1 and out_data keeps the first word; one cycle of out_ready=1 → out_valid falls on the next edge.
- Simultaneous events: seed_we and en both high → seed loaded with no shift. Word completion on the same edge as a transfer → out_valid stays 1 and overrun stays 0.
- Reset: assert rst mid-RUN between clock edges → all outputs 0 immediately; after release, state is IDLE until en=1.
